svm_exec_dispatcher: RTL and testbench



---
 rtl/svm_exec_dispatcher.sv | 210 +++++++++++++++++++++
 tb/tb_svm_exec_dispatcher.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/svm_exec_dispatcher.sv
// Dispatches scheduler transactions to a pool of execution units, holding any
// transaction whose read/write sets overlap work that is still executing.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   s_axis_tvalid/tready          : transaction handshake from the scheduler
//   s_axis_tdata_*                : owner ID, read set, write set
//   dispatch_valid[u]             : one-cycle start pulse to unit u
//   dispatch_owner_programID      : owner ID per unit (64 bits per unit)
//   unit_done[u]                  : one-cycle completion pulse from unit u
//   unit_busy, inflight_count     : busy map and its population count
//   dispatched_count              : saturating dispatch counter
//   conflict_stall_cycles         : saturating count of dependency stalls
//   unit_stall_cycles             : saturating count of no-free-unit stalls
module svm_exec_dispatcher #(
    parameter int MAX_DEPENDENCIES = 256,
    parameter int NUM_UNITS        = 4,
    parameter int UNIT_IDX_W       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [63:0]                 s_axis_tdata_owner_programID,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
    input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
    output logic [NUM_UNITS-1:0]        dispatch_valid,
    output logic [64*NUM_UNITS-1:0]     dispatch_owner_programID,
    input  logic [NUM_UNITS-1:0]        unit_done,
    output logic [NUM_UNITS-1:0]        unit_busy,
    output logic [UNIT_IDX_W:0]         inflight_count,
    output logic [31:0]                 dispatched_count,
    output logic [31:0]                 conflict_stall_cycles,
    output logic [31:0]                 unit_stall_cycles
);

    localparam int IW1 = UNIT_IDX_W + 1;
    localparam logic [IW1-1:0] NU = IW1'(NUM_UNITS);

    // Hold register
    logic                        hold_valid_q, hold_valid_d;
    logic [63:0]                 hold_owner_q, hold_owner_d;
    logic [MAX_DEPENDENCIES-1:0] hold_rd_q, hold_rd_d;
    logic [MAX_DEPENDENCIES-1:0] hold_wr_q, hold_wr_d;

    // Per-unit state
    logic [MAX_DEPENDENCIES-1:0] unit_rd_q [NUM_UNITS];
    logic [MAX_DEPENDENCIES-1:0] unit_rd_d [NUM_UNITS];
    logic [MAX_DEPENDENCIES-1:0] unit_wr_q [NUM_UNITS];
    logic [MAX_DEPENDENCIES-1:0] unit_wr_d [NUM_UNITS];
    logic [NUM_UNITS-1:0]        unit_busy_q, unit_busy_d;
    logic [NUM_UNITS-1:0]        dispatch_valid_q, dispatch_valid_d;
    logic [64*NUM_UNITS-1:0]     dispatch_owner_q, dispatch_owner_d;
    logic [UNIT_IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW1-1:0]              inflight_count_q, inflight_count_d;

    logic [31:0] dispatched_q, dispatched_d;
    logic [31:0] cstall_q, cstall_d;
    logic [31:0] ustall_q, ustall_d;

    // Combinational helpers
    logic [MAX_DEPENDENCIES-1:0] inflight_rd, inflight_wr;
    logic                        conflict;
    logic                        free_found;
    logic [UNIT_IDX_W-1:0]       free_idx;
    logic [IW1-1:0]              cand;
    logic [IW1-1:0]              rr_next;
    logic                        fire;
    logic                        accept;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        inflight_rd = '0;
        inflight_wr = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_busy_q[u]) begin
                inflight_rd = inflight_rd | unit_rd_q[u];
                inflight_wr = inflight_wr | unit_wr_q[u];
            end
        end

        // RAW, WAW and WAR against everything still executing
        conflict = (|(hold_rd_q & inflight_wr))
                 | (|(hold_wr_q & inflight_wr))
                 | (|(hold_wr_q & inflight_rd));

        // Round-robin search starting at rr_ptr, wrapping modulo NUM_UNITS
        free_found = 1'b0;
        free_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand = {1'b0, rr_ptr_q} + IW1'(i);
            if (cand >= NU) begin
                cand = cand - NU;
            end
            if (!free_found && !unit_busy_q[cand[UNIT_IDX_W-1:0]]) begin
                free_found = 1'b1;
                free_idx   = cand[UNIT_IDX_W-1:0];
            end
        end

        fire          = hold_valid_q && !conflict && free_found;
        s_axis_tready = !hold_valid_q || fire;
        accept        = s_axis_tvalid && s_axis_tready;

        hold_valid_d = hold_valid_q;
        hold_owner_d = hold_owner_q;
        hold_rd_d    = hold_rd_q;
        hold_wr_d    = hold_wr_q;
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_owner_d = s_axis_tdata_owner_programID;
            hold_rd_d    = s_axis_tdata_read_dependencies;
            hold_wr_d    = s_axis_tdata_write_dependencies;
        end else if (fire) begin
            hold_valid_d = 1'b0;
        end

        unit_busy_d      = unit_busy_q;
        unit_rd_d        = unit_rd_q;
        unit_wr_d        = unit_wr_q;
        dispatch_valid_d = '0;
        dispatch_owner_d = dispatch_owner_q;
        rr_ptr_d         = rr_ptr_q;
        rr_next          = '0;

        // Completions on idle units are ignored
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_done[u] && unit_busy_q[u]) begin
                unit_busy_d[u] = 1'b0;
                unit_rd_d[u]   = '0;
                unit_wr_d[u]   = '0;
            end
        end

        // Selected unit is idle, so it never collides with its own done
        if (fire) begin
            unit_busy_d[free_idx]      = 1'b1;
            unit_rd_d[free_idx]        = hold_rd_q;
            unit_wr_d[free_idx]        = hold_wr_q;
            dispatch_valid_d[free_idx] = 1'b1;
            dispatch_owner_d[int'(free_idx)*64 +: 64] = hold_owner_q;
            rr_next = {1'b0, free_idx} + IW1'(1);
            if (rr_next >= NU) begin
                rr_next = '0;
            end
            rr_ptr_d = rr_next[UNIT_IDX_W-1:0];
        end

        inflight_count_d = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            inflight_count_d = inflight_count_d + IW1'(unit_busy_d[u]);
        end

        dispatched_d = fire ? sat_inc(dispatched_q) : dispatched_q;
        cstall_d = (hold_valid_q && conflict) ? sat_inc(cstall_q) : cstall_q;
        ustall_d = (hold_valid_q && !conflict && !free_found)
                 ? sat_inc(ustall_q) : ustall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q     <= 1'b0;
            hold_owner_q     <= '0;
            hold_rd_q        <= '0;
            hold_wr_q        <= '0;
            unit_busy_q      <= '0;
            dispatch_valid_q <= '0;
            dispatch_owner_q <= '0;
            rr_ptr_q         <= '0;
            inflight_count_q <= '0;
            dispatched_q     <= '0;
            cstall_q         <= '0;
            ustall_q         <= '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                unit_rd_q[u] <= '0;
                unit_wr_q[u] <= '0;
            end
        end else begin
            hold_valid_q     <= hold_valid_d;
            hold_owner_q     <= hold_owner_d;
            hold_rd_q        <= hold_rd_d;
            hold_wr_q        <= hold_wr_d;
            unit_busy_q      <= unit_busy_d;
            dispatch_valid_q <= dispatch_valid_d;
            dispatch_owner_q <= dispatch_owner_d;
            rr_ptr_q         <= rr_ptr_d;
            inflight_count_q <= inflight_count_d;
            dispatched_q     <= dispatched_d;
            cstall_q         <= cstall_d;
            ustall_q         <= ustall_d;
            for (int u = 0; u < NUM_UNITS; u++) begin
                unit_rd_q[u] <= unit_rd_d[u];
                unit_wr_q[u] <= unit_wr_d[u];
            end
        end
    end

    assign dispatch_valid           = dispatch_valid_q;
    assign dispatch_owner_programID = dispatch_owner_q;
    assign unit_busy                = unit_busy_q;
    assign inflight_count           = inflight_count_q;
    assign dispatched_count         = dispatched_q;
    assign conflict_stall_cycles    = cstall_q;
    assign unit_stall_cycles        = ustall_q;

endmodule

// File: tb/tb_svm_exec_dispatcher.sv
// Directed table-driven bench for svm_exec_dispatcher: one row per clock,
// expected state after each edge, plus a bounded release/dispatch sequence.
module tb_svm_exec_dispatcher;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [63:0]  s_axis_tdata_owner_programID;
    logic [255:0] s_axis_tdata_read_dependencies;
    logic [255:0] s_axis_tdata_write_dependencies;
    logic [3:0]   dispatch_valid;
    logic [255:0] dispatch_owner_programID;
    logic [3:0]   unit_done;
    logic [3:0]   unit_busy;
    logic [2:0]   inflight_count;
    logic [31:0]  dispatched_count;
    logic [31:0]  conflict_stall_cycles;
    logic [31:0]  unit_stall_cycles;

    svm_exec_dispatcher dut (
        .clk                             (clk),
        .rst                             (rst),
        .s_axis_tvalid                   (s_axis_tvalid),
        .s_axis_tready                   (s_axis_tready),
        .s_axis_tdata_owner_programID    (s_axis_tdata_owner_programID),
        .s_axis_tdata_read_dependencies  (s_axis_tdata_read_dependencies),
        .s_axis_tdata_write_dependencies (s_axis_tdata_write_dependencies),
        .dispatch_valid                  (dispatch_valid),
        .dispatch_owner_programID        (dispatch_owner_programID),
        .unit_done                       (unit_done),
        .unit_busy                       (unit_busy),
        .inflight_count                  (inflight_count),
        .dispatched_count                (dispatched_count),
        .conflict_stall_cycles           (conflict_stall_cycles),
        .unit_stall_cycles               (unit_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        tv;
        logic [15:0] own;
        logic [15:0] rd;
        logic [15:0] wr;
        logic [3:0]  done;
        logic [3:0]  e_dv;
        logic [3:0]  e_busy;
        logic        e_rdy;
        logic [2:0]  e_inf;
        int          e_disp;
        int          e_cst;
        int          e_ust;
        int          own_u;
        logic [15:0] own_v;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic void add(
        input logic rs, input logic tv, input logic [15:0] own,
        input logic [15:0] rd, input logic [15:0] wr, input logic [3:0] dn,
        input logic [3:0] dv, input logic [3:0] bz, input logic rdy,
        input logic [2:0] inf, input int dsp, input int cst, input int ust,
        input int ou, input logic [15:0] ov);
        vec_t v;
        v.rst = rs; v.tv = tv; v.own = own; v.rd = rd; v.wr = wr;
        v.done = dn; v.e_dv = dv; v.e_busy = bz; v.e_rdy = rdy;
        v.e_inf = inf; v.e_disp = dsp; v.e_cst = cst; v.e_ust = ust;
        v.own_u = ou; v.own_v = ov;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s row %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic tv, input logic [15:0] own,
                         input logic [15:0] rd, input logic [15:0] wr,
                         input logic [3:0] dn);
        rst = rs;
        s_axis_tvalid = tv;
        s_axis_tdata_owner_programID = {48'd0, own};
        s_axis_tdata_read_dependencies = {240'd0, rd};
        s_axis_tdata_write_dependencies = {240'd0, wr};
        unit_done = dn;
    endtask

    initial begin
        bit got;
        int waited;

        drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 4'h0);

        //  rst tv own    rd     wr     done | dv  busy rdy inf disp cst ust ou ov
        add(1, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 16'h00);
        // independent stream
        add(0, 1, 16'h01, 16'h0, 16'h1, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 16'h00);
        add(0, 1, 16'h02, 16'h0, 16'h2, 4'h0, 4'h1, 4'h1, 1, 1, 1, 0, 0, 0, 16'h01);
        add(0, 1, 16'h03, 16'h0, 16'h4, 4'h0, 4'h2, 4'h3, 1, 2, 2, 0, 0, 1, 16'h02);
        add(0, 1, 16'h04, 16'h0, 16'h8, 4'h0, 4'h4, 4'h7, 1, 3, 3, 0, 0, 2, 16'h03);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h8, 4'hF, 1, 4, 4, 0, 0, 3, 16'h04);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'hF, 4'h0, 4'h0, 1, 0, 4, 0, 0, 0, 16'h01);
        // RAW
        add(0, 1, 16'h11, 16'h0, 16'h2, 4'h0, 4'h0, 4'h0, 1, 0, 4, 0, 0, 0, 16'h01);
        add(0, 1, 16'h12, 16'h2, 16'h0, 4'h0, 4'h1, 4'h1, 0, 1, 5, 0, 0, 0, 16'h11);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h0, 4'h1, 0, 1, 5, 1, 0, 0, 16'h11);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h0, 4'h1, 0, 1, 5, 2, 0, 0, 16'h11);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h1, 4'h0, 4'h0, 1, 0, 5, 3, 0, 0, 16'h11);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h2, 4'h2, 1, 1, 6, 3, 0, 1, 16'h12);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h2, 4'h0, 4'h0, 1, 0, 6, 3, 0, 0, 16'h11);
        // WAW then WAR
        add(0, 1, 16'h13, 16'h0, 16'h20, 4'h0, 4'h0, 4'h0, 1, 0, 6, 3, 0, 0, 16'h11);
        add(0, 1, 16'h14, 16'h0, 16'h20, 4'h0, 4'h4, 4'h4, 0, 1, 7, 3, 0, 2, 16'h13);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h0, 4'h4, 0, 1, 7, 4, 0, 0, 16'h11);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h4, 4'h0, 4'h0, 1, 0, 7, 5, 0, 0, 16'h11);
        add(0, 1, 16'h15, 16'h200, 16'h0, 4'h0, 4'h8, 4'h8, 1, 1, 8, 5, 0, 3, 16'h14);
        add(0, 1, 16'h16, 16'h0, 16'h200, 4'h0, 4'h1, 4'h9, 0, 2, 9, 5, 0, 0, 16'h15);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h0, 4'h9, 0, 2, 9, 6, 0, 0, 16'h15);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h1, 4'h0, 4'h8, 1, 1, 9, 7, 0, 0, 16'h15);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h2, 4'hA, 1, 2, 10, 7, 0, 1, 16'h16);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'hA, 4'h0, 4'h0, 1, 0, 10, 7, 0, 0, 16'h15);
        // unit exhaustion, rr wrap 3 -> 0
        add(0, 1, 16'h21, 16'h0, 16'h1, 4'h0, 4'h0, 4'h0, 1, 0, 10, 7, 0, 0, 16'h15);
        add(0, 1, 16'h22, 16'h0, 16'h2, 4'h0, 4'h4, 4'h4, 1, 1, 11, 7, 0, 2, 16'h21);
        add(0, 1, 16'h23, 16'h0, 16'h4, 4'h0, 4'h8, 4'hC, 1, 2, 12, 7, 0, 3, 16'h22);
        add(0, 1, 16'h24, 16'h0, 16'h8, 4'h0, 4'h1, 4'hD, 1, 3, 13, 7, 0, 0, 16'h23);
        add(0, 1, 16'h25, 16'h0, 16'h10, 4'h0, 4'h2, 4'hF, 0, 4, 14, 7, 0, 1, 16'h24);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h0, 4'hF, 0, 4, 14, 7, 1, 0, 16'h23);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h0, 4'hF, 0, 4, 14, 7, 2, 0, 16'h23);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h4, 4'h0, 4'hB, 1, 3, 14, 7, 3, 0, 16'h23);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h4, 4'hF, 1, 4, 15, 7, 3, 2, 16'h25);
        // release unit 3, then a spurious done on it
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h8, 4'h0, 4'h7, 1, 3, 15, 7, 3, 0, 16'h23);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h8, 4'h0, 4'h7, 1, 3, 15, 7, 3, 0, 16'h23);
        // held conflicting transaction, then reset mid-operation
        add(0, 1, 16'h31, 16'h10, 16'h0, 4'h0, 4'h0, 4'h7, 0, 3, 15, 7, 3, 0, 16'h23);
        add(0, 1, 16'h32, 16'h0, 16'h0, 4'h0, 4'h0, 4'h7, 0, 3, 15, 8, 3, 0, 16'h23);
        add(1, 1, 16'h32, 16'h0, 16'h0, 4'h7, 4'h0, 4'h0, 1, 0, 0, 0, 0, 2, 16'h00);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 2, 16'h00);
        // zero-dependency transactions while unit 0 busy
        add(0, 1, 16'h41, 16'h0, 16'h80, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 16'h00);
        add(0, 1, 16'h42, 16'h0, 16'h0, 4'h0, 4'h1, 4'h1, 1, 1, 1, 0, 0, 0, 16'h41);
        add(0, 1, 16'h43, 16'h0, 16'h0, 4'h0, 4'h2, 4'h3, 1, 2, 2, 0, 0, 1, 16'h42);
        add(0, 1, 16'h44, 16'h0, 16'h0, 4'h0, 4'h4, 4'h7, 1, 3, 3, 0, 0, 2, 16'h43);
        add(0, 0, 16'h00, 16'h0, 16'h0, 4'h0, 4'h8, 4'hF, 1, 4, 4, 0, 0, 3, 16'h44);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].tv, tbl[i].own, tbl[i].rd, tbl[i].wr,
                  tbl[i].done);
            @(posedge clk);
            #1;
            chk("dispatch_valid", i, 64'(dispatch_valid), 64'(tbl[i].e_dv));
            chk("unit_busy", i, 64'(unit_busy), 64'(tbl[i].e_busy));
            chk("tready", i, 64'(s_axis_tready), 64'(tbl[i].e_rdy));
            chk("inflight", i, 64'(inflight_count), 64'(tbl[i].e_inf));
            chk("dispatched", i, 64'(dispatched_count), 64'(tbl[i].e_disp));
            chk("conf_stall", i, 64'(conflict_stall_cycles),
                64'(tbl[i].e_cst));
            chk("unit_stall", i, 64'(unit_stall_cycles), 64'(tbl[i].e_ust));
            chk("owner", i, dispatch_owner_programID[tbl[i].own_u*64 +: 64],
                64'(tbl[i].own_v));
        end

        // All units busy: accept, hold, release unit 1, bounded wait
        drive(1'b0, 1'b1, 16'h51, 16'h0, 16'h0, 4'h0);
        @(posedge clk);
        #1;
        chk("seq_hold_rdy", 100, 64'(s_axis_tready), 64'd0);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 4'h2);
        @(posedge clk);
        #1;
        unit_done = 4'h0;
        chk("seq_no_early", 101, 64'(dispatch_valid), 64'd0);
        got = 1'b0;
        waited = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk);
            #1;
            waited++;
            if (dispatch_valid != 4'h0) got = 1'b1;
        end
        if (!got) begin
            nerr++;
            $display("FAIL seq_timeout: got no dispatch want dispatch in 8");
        end
        chk("seq_latency", 102, 64'(waited), 64'd1);
        chk("seq_dv", 103, 64'(dispatch_valid), 64'h2);
        chk("seq_owner", 104, dispatch_owner_programID[64 +: 64], 64'h51);
        chk("seq_ustall", 105, 64'(unit_stall_cycles), 64'd1);
        chk("seq_disp", 106, 64'(dispatched_count), 64'd5);
        chk("seq_busy", 107, 64'(unit_busy), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
